cdb_broadcaster: RTL

Producer side of the common data bus in the out-of-order core. Collects completed results from the functional units (ALU, MUL, BR, MEM) through per-source valid/ready handshakes. Buffers each source in a small FIFO and broadcasts one result per cycle on a registered CDB port. That port feeds the reservation stations, ROB and register file.

---
 rtl/cdb_broadcaster.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdb_broadcaster                                            |
// | Description : Producer side of the common data bus. Each functional-unit |
// |               source feeds a small FIFO through a valid/ready handshake; |
// |               one buffered result per cycle is chosen and broadcast on   |
// |               a registered CDB port.                                     |
// | Ports       : clk, rst (async, active-low), flush (sync)                 |
// |               rob_head_idx        - ROB head used for age ordering       |
// |               src_valid/src_ready - per-source handshake                 |
// |               src_rob_idx/src_rd_addr/src_data - packed per-source data  |
// |               cdb_valid/cdb_src_id/cdb_rob_idx/cdb_rd_addr/cdb_data      |
// |                                   - registered broadcast                 |
// | Config      : define CDB_RR_ARB_EN for round-robin arbitration instead   |
// |               of oldest-first (ROB age) arbitration.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cdb_broadcaster #(
  parameter int NUM_SRC        = 4,
  parameter int FIFO_DEPTH     = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ROB_IDX_WIDTH  = 5,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int SRC_W         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [ROB_IDX_WIDTH-1:0]           rob_head_idx,
  input  logic [NUM_SRC-1:0]                 src_valid,
  output logic [NUM_SRC-1:0]                 src_ready,
  input  logic [NUM_SRC*ROB_IDX_WIDTH-1:0]   src_rob_idx,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]  src_rd_addr,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data,
  output logic                               cdb_valid,
  output logic [SRC_W-1:0]                   cdb_src_id,
  output logic [ROB_IDX_WIDTH-1:0]           cdb_rob_idx,
  output logic [REG_ADDR_WIDTH-1:0]          cdb_rd_addr,
  output logic [DATA_WIDTH-1:0]              cdb_data
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ROB_IDX_WIDTH + REG_ADDR_WIDTH + DATA_WIDTH;

  // Per-source FIFO head view, consumed by the arbiter and the CDB registers.
  logic [NUM_SRC-1:0]        nonempty;
  logic [ROB_IDX_WIDTH-1:0]  head_rob  [NUM_SRC];
  logic [REG_ADDR_WIDTH-1:0] head_rd   [NUM_SRC];
  logic [DATA_WIDTH-1:0]     head_data [NUM_SRC];

  logic                      grant_valid;
  logic [SRC_W-1:0]          grant_id;

  // --------------------------------------------------------------------------
  // Per-source FIFOs
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Ready comes straight from the count flop: a full FIFO refuses a push
    // even in a cycle where it is also being popped.
    assign src_ready[i] = (count != CNT_W'(FIFO_DEPTH));
    assign push         = src_valid[i] && src_ready[i] && !flush;
    assign pop          = grant_valid && (grant_id == SRC_W'(i)) && !flush;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= {src_rob_idx[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH],
                        src_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH],
                        src_data[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    assign head         = mem[rd_ptr];
    assign nonempty[i]  = (count != '0);
    assign head_rob[i]  = head[ENTRY_W-1 -: ROB_IDX_WIDTH];
    assign head_rd[i]   = head[DATA_WIDTH +: REG_ADDR_WIDTH];
    assign head_data[i] = head[DATA_WIDTH-1:0];
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef CDB_RR_ARB_EN
  logic [SRC_W-1:0] rr_ptr;
  logic             unused_rob_head;

  // Age is irrelevant in round-robin mode.
  assign unused_rob_head = ^rob_head_idx;

  // Scan offsets from the highest down so the smallest offset from the
  // pointer (first non-empty source at or after it) is the last writer.
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (nonempty[idx]) begin
        grant_valid = 1'b1;
        grant_id    = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_id == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id + SRC_W'(1);
    end
  end
`else
  // Oldest-first: age is the modular distance from the ROB head. A strict
  // less-than keeps the lowest source index on equal age.
  always_comb begin
    logic [ROB_IDX_WIDTH-1:0] age;
    logic [ROB_IDX_WIDTH-1:0] best_age;
    grant_valid = 1'b0;
    grant_id    = '0;
    age         = '0;
    best_age    = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      age = head_rob[k] - rob_head_idx;
      if (nonempty[k] && (!grant_valid || (age < best_age))) begin
        grant_valid = 1'b1;
        grant_id    = SRC_W'(k);
        best_age    = age;
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Registered CDB port; payload holds when nothing is granted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_valid   <= 1'b0;
      cdb_src_id  <= '0;
      cdb_rob_idx <= '0;
      cdb_rd_addr <= '0;
      cdb_data    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_src_id  <= grant_id;
        cdb_rob_idx <= head_rob[grant_id];
        cdb_rd_addr <= head_rd[grant_id];
        cdb_data    <= head_data[grant_id];
      end
    end
  end

endmodule
`default_nettype wire
